sram_arbiter: RTL and testbench
===============================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2, meaning strobe-active cycles per access (legal range 1-15).
REQ-002 SHALL have port clk  input  1  single system clock; all logic in this one domain.
REQ-003 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports cpu_req  input  1, cpu_we  input  1, cpu_addr  input  19, cpu_wdata  input  8  CPU request, direction (1 = write), address and write data.
REQ-005 SHALL have ports cpu_ack  output  1, cpu_rdata  output  8  CPU completion pulse and read data.
REQ-006 SHALL have ports adc_req  input  1, adc_addr  input  19, adc_wdata  input  8  ADC capture write request (always a write).
REQ-007 SHALL have port adc_ack  output  1  ADC completion pulse.
REQ-008 SHALL have ports sram_addr  output  19, sram_dout  output  8, sram_din  input  8, sram_oe  output  1  SRAM address, write data, read data and data-pad output enable (1 = FPGA drives D bus).
REQ-009 SHALL have ports sram_ce_n, sram_oe_n, sram_we_n  output  1 each  active-low SRAM strobes.
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-011 SHALL implement FSM states IDLE, SETUP, STROBE, HOLD; transitions IDLE->SETUP on any granted request, SETUP->STROBE after 1 cycle, STROBE->HOLD after WAIT_CYCLES cycles, HOLD->IDLE after 1 cycle.
REQ-012 SHALL arbitrate in IDLE only: single requester wins; both requesting -> the requester not granted most recently wins (round-robin); after reset the ADC has priority.
REQ-013 SHALL register address, direction and write data of the winner on the IDLE->SETUP edge; requester input changes after that edge SHALL NOT affect the access.
REQ-014 Requesters SHALL hold req asserted until ack; arbiter SHALL ignore a req that is still high in the cycle immediately after its ack (re-arbitration resumes the following IDLE cycle).
REQ-015 Write: SETUP drives sram_addr, sram_dout, sram_oe=1, sram_ce_n=0, sram_we_n=1; STROBE drives sram_we_n=0; HOLD drives sram_we_n=1 with address, data and sram_oe held.
REQ-016 Read: SETUP and STROBE drive sram_ce_n=0, sram_oe_n=0, sram_oe=0; sram_din SHALL be sampled on the final STROBE cycle into cpu_rdata; HOLD drives sram_oe_n=1.
REQ-017 sram_oe and sram_we_n=0 SHALL never be asserted while sram_oe_n=0 (no bus contention).
REQ-018 ack SHALL pulse high for exactly one cycle, in the HOLD state, to the granted requester only.
REQ-019 Access latency from the IDLE cycle of grant to ack SHALL be WAIT_CYCLES+2 cycles; back-to-back accesses SHALL occupy WAIT_CYCLES+3 cycles each.
REQ-020 cpu_rdata SHALL hold its last read value until the next CPU read completes; ADC accesses and CPU writes SHALL NOT change it.
REQ-021 STROBE counter SHALL be 4 bits, load WAIT_CYCLES-1 on SETUP exit, decrement to 0, never wrap.
REQ-022 In IDLE: sram_ce_n=1, sram_oe_n=1, sram_we_n=1, sram_oe=0; sram_addr and sram_dout hold last values.

Reset
REQ-023 reset_n low SHALL immediately force state IDLE, sram_ce_n=sram_oe_n=sram_we_n=1, sram_oe=0, cpu_ack=adc_ack=0, busy=0, sram_addr=0, sram_dout=0, cpu_rdata=0, round-robin pointer = ADC priority.
REQ-024 Reset asserted mid-access SHALL abort it without ack; the access is not retried after reset release.
REQ-025 First arbitration SHALL occur on the first rising clk edge after reset_n deassertion.

Verification
REQ-026 CPU write 0x12345 <- 0xA5, WAIT_CYCLES=2 -> sram_we_n low exactly 2 cycles, sram_oe=1 from SETUP through HOLD, cpu_ack at cycle 4 after grant.
REQ-027 CPU read 0x00010 with sram_din model returning 0x5A -> cpu_rdata=0x5A at cpu_ack, sram_oe=0 throughout, sram_oe_n low for 3 cycles.
REQ-028 cpu_req and adc_req both held continuously after reset -> grants alternate ADC, CPU, ADC, CPU; each ack spaced 5 cycles apart.
REQ-029 reset_n pulsed low during STROBE of a write -> strobes high and sram_oe=0 same cycle, no ack issued, busy=0.
REQ-030 Random CPU/ADC traffic against SRAM model, WAIT_CYCLES in {1,2,7} -> all reads return last written data, no contention per REQ-017, one ack per request.

Source files
------------

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - round-robin CPU/ADC arbiter driving one asynchronous byte-wide SRAM
//
// Purpose: grants one of two requesters (CPU read/write, ADC write-only) at a
// time and sequences the SRAM strobes through IDLE -> SETUP -> STROBE -> HOLD.
// STROBE lasts WAIT_CYCLES cycles (1..15).
//
// Ports:
//   clk, reset_n                        clock, asynchronous active-low reset
//   cpu_req/cpu_we/cpu_addr/cpu_wdata   CPU request, direction (1 = write), address, data
//   cpu_ack, cpu_rdata                  CPU completion pulse, last CPU read data
//   adc_req/adc_addr/adc_wdata          ADC write request, address, data
//   adc_ack                             ADC completion pulse
//   sram_addr, sram_dout, sram_din      SRAM address, write data, read data
//   sram_oe                             1 = FPGA drives the SRAM data pads
//   sram_ce_n, sram_oe_n, sram_we_n     active-low SRAM strobes
//   busy                                high whenever an access is in flight
module sram_arbiter #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [18:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,
    output logic [7:0]  cpu_rdata,
    input  logic        adc_req,
    input  logic [18:0] adc_addr,
    input  logic [7:0]  adc_wdata,
    output logic        adc_ack,
    output logic [18:0] sram_addr,
    output logic [7:0]  sram_dout,
    input  logic [7:0]  sram_din,
    output logic        sram_oe,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_STROBE = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    localparam logic [3:0] STROBE_LOAD = 4'(WAIT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    // Owner of the current (or most recent) access; doubles as the
    // round-robin pointer. Reset to "CPU" so the ADC wins the first tie.
    logic        gnt_cpu_q, gnt_cpu_d;
    logic        we_q, we_d;
    logic [18:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  rdata_q, rdata_d;
    // High for the IDLE cycle right after HOLD: the requester just acked may
    // still have req high and must not be granted a second time on it.
    logic        post_hold_q;

    logic cpu_ok, adc_ok, pick_cpu, grant, last_strobe;

    always_comb begin
        cpu_ok      = cpu_req & ~(post_hold_q & gnt_cpu_q);
        adc_ok      = adc_req & ~(post_hold_q & ~gnt_cpu_q);
        pick_cpu    = cpu_ok & (~adc_ok | ~gnt_cpu_q);
        grant       = (state_q == S_IDLE) & (cpu_ok | adc_ok);
        last_strobe = (state_q == S_STROBE) & (cnt_q == 4'd0);
    end

    // State register and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            gnt_cpu_q   <= 1'b1;
            we_q        <= 1'b0;
            addr_q      <= 19'd0;
            wdata_q     <= 8'd0;
            rdata_q     <= 8'd0;
            post_hold_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gnt_cpu_q   <= gnt_cpu_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            post_hold_q <= (state_q == S_HOLD);
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (grant) state_d = S_SETUP;
            end
            S_SETUP: begin
                state_d = S_STROBE;
                cnt_d   = STROBE_LOAD;
            end
            S_STROBE: begin
                if (cnt_q == 4'd0) state_d = S_HOLD;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_HOLD: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Winner's request is captured on the grant edge; read data is captured
    // on the last STROBE edge of a CPU read only.
    always_comb begin
        gnt_cpu_d = gnt_cpu_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        if (grant) begin
            gnt_cpu_d = pick_cpu;
            we_d      = pick_cpu ? cpu_we    : 1'b1;
            addr_d    = pick_cpu ? cpu_addr  : adc_addr;
            wdata_d   = pick_cpu ? cpu_wdata : adc_wdata;
        end
        if (last_strobe && gnt_cpu_q && !we_q) rdata_d = sram_din;
    end

    // Output decode. sram_oe is only raised for writes and sram_oe_n only
    // lowered for reads, so the pads are never driven against the SRAM.
    always_comb begin
        sram_ce_n = 1'b1;
        sram_oe_n = 1'b1;
        sram_we_n = 1'b1;
        sram_oe   = 1'b0;
        cpu_ack   = 1'b0;
        adc_ack   = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
            end
            S_SETUP: begin
                busy      = 1'b1;
                sram_ce_n = 1'b0;
                sram_oe   = we_q;
                sram_oe_n = we_q;
            end
            S_STROBE: begin
                busy      = 1'b1;
                sram_ce_n = 1'b0;
                sram_oe   = we_q;
                sram_oe_n = we_q;
                sram_we_n = ~we_q;
            end
            S_HOLD: begin
                busy      = 1'b1;
                sram_ce_n = 1'b0;
                sram_oe   = we_q;
                cpu_ack   = gnt_cpu_q;
                adc_ack   = ~gnt_cpu_q;
            end
        endcase
    end

    assign sram_addr = addr_q;
    assign sram_dout = wdata_q;
    assign cpu_rdata = rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - self-checking bench for sram_arbiter at WAIT_CYCLES 1, 2 and 7
module tb_sram_arbiter;

    localparam int N = 3;

    function automatic int wait_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 2 : 7);
    endfunction

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n   [N];
    logic        cpu_req   [N];
    logic        cpu_we    [N];
    logic [18:0] cpu_addr  [N];
    logic [7:0]  cpu_wdata [N];
    logic        cpu_ack   [N];
    logic [7:0]  cpu_rdata [N];
    logic        adc_req   [N];
    logic [18:0] adc_addr  [N];
    logic [7:0]  adc_wdata [N];
    logic        adc_ack   [N];
    logic [18:0] sram_addr [N];
    logic [7:0]  sram_dout [N];
    logic [7:0]  sram_din  [N];
    logic        sram_oe   [N];
    logic        sram_ce_n [N];
    logic        sram_oe_n [N];
    logic        sram_we_n [N];
    logic        busy      [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        sram_arbiter #(.WAIT_CYCLES(g == 0 ? 1 : (g == 1 ? 2 : 7))) u_dut (
            .clk       (clk),
            .reset_n   (reset_n[g]),
            .cpu_req   (cpu_req[g]),
            .cpu_we    (cpu_we[g]),
            .cpu_addr  (cpu_addr[g]),
            .cpu_wdata (cpu_wdata[g]),
            .cpu_ack   (cpu_ack[g]),
            .cpu_rdata (cpu_rdata[g]),
            .adc_req   (adc_req[g]),
            .adc_addr  (adc_addr[g]),
            .adc_wdata (adc_wdata[g]),
            .adc_ack   (adc_ack[g]),
            .sram_addr (sram_addr[g]),
            .sram_dout (sram_dout[g]),
            .sram_din  (sram_din[g]),
            .sram_oe   (sram_oe[g]),
            .sram_ce_n (sram_ce_n[g]),
            .sram_oe_n (sram_oe_n[g]),
            .sram_we_n (sram_we_n[g]),
            .busy      (busy[g])
        );
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // SRAM model (low 12 address bits) plus bus-contention monitor
    logic [7:0] mem [N][4096];
    bit         mem_ready = 1'b0;
    int         viol [N];

    always @(negedge clk) begin
        if (!mem_ready) begin
            for (int k = 0; k < N; k++)
                for (int a = 0; a < 4096; a++) mem[k][a] <= 8'h00;
            mem_ready <= 1'b1;
        end
        for (int k = 0; k < N; k++) begin
            if (!sram_ce_n[k] && !sram_we_n[k]) mem[k][sram_addr[k][11:0]] <= sram_dout[k];
            if (!sram_ce_n[k] && !sram_oe_n[k]) sram_din[k] <= mem[k][sram_addr[k][11:0]];
            else                                sram_din[k] <= 8'hEE;
            if (!sram_oe_n[k] && (sram_oe[k] || !sram_we_n[k])) viol[k] <= viol[k] + 1;
        end
    end

    typedef struct {
        bit          is_cpu;
        bit          we;
        logic [18:0] addr;
        logic [7:0]  wdata;
        int          exp_lat;
        int          exp_we_low;
        int          exp_oen_low;
        int          exp_oe_hi;
        logic [7:0]  exp_rdata;
    } vec_t;

    task automatic idle_inputs(input int k);
        cpu_req[k] = 1'b0; cpu_we[k] = 1'b0; cpu_addr[k] = '0; cpu_wdata[k] = '0;
        adc_req[k] = 1'b0; adc_addr[k] = '0; adc_wdata[k] = '0;
    endtask

    task automatic run_one(input int k, input vec_t v);
        int lat = 0, we_low = 0, oen_low = 0, oe_hi = 0;
        bit got = 1'b0, other = 1'b0;
        logic [18:0] addr_at = '0;
        logic [7:0]  dout_at = '0, rdata_at = '0;
        @(negedge clk);
        if (v.is_cpu) begin
            cpu_req[k] = 1'b1; cpu_we[k] = v.we; cpu_addr[k] = v.addr; cpu_wdata[k] = v.wdata;
        end else begin
            adc_req[k] = 1'b1; adc_addr[k] = v.addr; adc_wdata[k] = v.wdata;
        end
        for (int i = 1; i <= 40 && !got; i++) begin
            @(negedge clk);
            if (!sram_we_n[k]) we_low++;
            if (!sram_oe_n[k]) oen_low++;
            if (sram_oe[k])    oe_hi++;
            if (v.is_cpu ? cpu_ack[k] : adc_ack[k]) begin
                got      = 1'b1;
                lat      = i;
                other    = v.is_cpu ? adc_ack[k] : cpu_ack[k];
                addr_at  = sram_addr[k];
                dout_at  = sram_dout[k];
                rdata_at = cpu_rdata[k];
            end
            if (i == 1) begin
                // the access must be immune to request changes after the grant
                cpu_addr[k] = ~v.addr; cpu_wdata[k] = ~v.wdata; cpu_we[k] = ~v.we;
                adc_addr[k] = ~v.addr; adc_wdata[k] = ~v.wdata;
            end
        end
        idle_inputs(k);
        check("ack latency", lat, v.exp_lat);
        check("we_n low cycles", we_low, v.exp_we_low);
        check("oe_n low cycles", oen_low, v.exp_oen_low);
        check("sram_oe high cycles", oe_hi, v.exp_oe_hi);
        check("addr at ack", addr_at, v.addr);
        check("other ack", other, 0);
        if (v.we) check("dout at ack", dout_at, v.wdata);
        check("cpu_rdata at ack", rdata_at, v.exp_rdata);
        @(negedge clk);
        check("ack/busy after hold", {cpu_ack[k], adc_ack[k], busy[k]}, 3'b000);
    endtask

    task automatic rand_run(input int k, input int ncyc);
        int          wk = wait_of(k);
        int          bound = 3 * (wk + 4);
        logic [7:0]  refm [16];
        bit          cp = 0, ap = 0, cp_we = 0, cpu_done, adc_done;
        int          cp_idx = 0, ap_idx = 0, cp_age = 0, ap_age = 0, n_req = 0, n_done = 0;
        logic [7:0]  cp_data = '0, ap_data = '0;
        for (int i = 0; i < 16; i++) refm[i] = 8'h00;
        for (int cyc = 0; cyc < ncyc + 2 * bound; cyc++) begin
            @(negedge clk);
            cpu_done = 1'b0; adc_done = 1'b0;
            if (cpu_ack[k]) begin
                if (!cp) check("rand cpu ack without request", 1, 0);
                else begin
                    if (cp_we) refm[cp_idx] = cp_data;
                    else check("rand cpu read data", cpu_rdata[k], refm[cp_idx]);
                    cp = 0; cpu_req[k] = 1'b0; n_done++; cpu_done = 1'b1;
                end
            end
            if (adc_ack[k]) begin
                if (!ap) check("rand adc ack without request", 1, 0);
                else begin
                    refm[ap_idx] = ap_data;
                    ap = 0; adc_req[k] = 1'b0; n_done++; adc_done = 1'b1;
                end
            end
            if (cp && ++cp_age > bound) begin
                check("rand cpu ack timeout", cp_age, bound);
                cp = 0; cpu_req[k] = 1'b0;
            end
            if (ap && ++ap_age > bound) begin
                check("rand adc ack timeout", ap_age, bound);
                ap = 0; adc_req[k] = 1'b0;
            end
            if (cyc < ncyc && !cp && !cpu_done && $urandom_range(0, 2) == 0) begin
                cp = 1; cp_age = 0; n_req++;
                cp_we = 1'($urandom_range(0, 1)); cp_idx = int'($urandom_range(0, 15));
                cp_data = 8'($urandom);
                cpu_req[k] = 1'b1; cpu_we[k] = cp_we;
                cpu_addr[k] = 19'h40800 | 19'(cp_idx); cpu_wdata[k] = cp_data;
            end
            if (cyc < ncyc && !ap && !adc_done && $urandom_range(0, 2) == 0) begin
                ap = 1; ap_age = 0; n_req++;
                ap_idx = int'($urandom_range(0, 15)); ap_data = 8'($urandom);
                adc_req[k] = 1'b1;
                adc_addr[k] = 19'h40800 | 19'(ap_idx); adc_wdata[k] = ap_data;
            end
        end
        check("rand outstanding requests", {cp, ap}, 2'b00);
        check("rand one ack per request", n_done, n_req);
    endtask

    vec_t vecs [9];

    initial begin
        int   t_ack [4];
        int   who [4];
        int   n_ack, cyc, acks_after;
        bit   seen;

        vecs[0] = '{1'b1, 1'b1, 19'h12345, 8'hA5, 4, 2, 0, 4, 8'h00};
        vecs[1] = '{1'b1, 1'b1, 19'h00010, 8'h5A, 4, 2, 0, 4, 8'h00};
        vecs[2] = '{1'b1, 1'b0, 19'h00010, 8'h00, 4, 0, 3, 0, 8'h5A};
        vecs[3] = '{1'b0, 1'b1, 19'h00020, 8'h33, 4, 2, 0, 4, 8'h5A};
        vecs[4] = '{1'b1, 1'b0, 19'h00020, 8'h00, 4, 0, 3, 0, 8'h33};
        vecs[5] = '{1'b1, 1'b1, 19'h00020, 8'h77, 4, 2, 0, 4, 8'h33};
        vecs[6] = '{1'b1, 1'b0, 19'h12345, 8'h00, 4, 0, 3, 0, 8'hA5};
        vecs[7] = '{1'b0, 1'b1, 19'h12345, 8'hC3, 4, 2, 0, 4, 8'hA5};
        vecs[8] = '{1'b1, 1'b0, 19'h00020, 8'h00, 4, 0, 3, 0, 8'h77};

        for (int k = 0; k < N; k++) begin
            reset_n[k] = 1'b0;
            idle_inputs(k);
        end
        repeat (3) @(negedge clk);

        check("reset strobes ce/oe/we_n", {sram_ce_n[1], sram_oe_n[1], sram_we_n[1]}, 3'b111);
        check("reset sram_oe", sram_oe[1], 0);
        check("reset acks", {cpu_ack[1], adc_ack[1]}, 2'b00);
        check("reset busy", busy[1], 0);
        check("reset sram_addr", sram_addr[1], 0);
        check("reset sram_dout", sram_dout[1], 0);
        check("reset cpu_rdata", cpu_rdata[1], 0);

        for (int k = 0; k < N; k++) reset_n[k] = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) run_one(1, vecs[i]);

        // single requester holding req past its ack: one masked IDLE cycle
        @(negedge clk);
        cpu_req[1] = 1'b1; cpu_we[1] = 1'b0; cpu_addr[1] = 19'h00010;
        n_ack = 0;
        for (int i = 1; i <= 40 && n_ack < 2; i++) begin
            @(negedge clk);
            if (cpu_ack[1]) begin t_ack[n_ack] = i; n_ack++; end
        end
        idle_inputs(1);
        check("held req first ack", t_ack[0], 4);
        check("held req ack spacing", t_ack[1] - t_ack[0], 6);
        repeat (2) @(negedge clk);

        // both requesting from reset release: ADC first, then alternating
        reset_n[1] = 1'b0;
        cpu_req[1] = 1'b1; cpu_we[1] = 1'b0; cpu_addr[1] = 19'h00010;
        adc_req[1] = 1'b1; adc_addr[1] = 19'h00030; adc_wdata[1] = 8'h11;
        @(negedge clk);
        reset_n[1] = 1'b1;
        n_ack = 0;
        for (int i = 1; i <= 60 && n_ack < 4; i++) begin
            @(negedge clk);
            if (cpu_ack[1] || adc_ack[1]) begin
                t_ack[n_ack] = i; who[n_ack] = cpu_ack[1] ? 1 : 0; n_ack++;
            end
        end
        idle_inputs(1);
        check("rr ack count", n_ack, 4);
        check("rr first ack after release", t_ack[0], 4);
        check("rr grant order (1=cpu)", {who[0][0], who[1][0], who[2][0], who[3][0]}, 4'b0101);
        for (int i = 1; i < 4; i++) check("rr ack spacing", t_ack[i] - t_ack[i-1], 5);
        repeat (2) @(negedge clk);

        // reset during the write strobe aborts without an ack
        cpu_req[1] = 1'b1; cpu_we[1] = 1'b1; cpu_addr[1] = 19'h00040; cpu_wdata[1] = 8'h99;
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            @(negedge clk);
            if (!sram_we_n[1]) seen = 1'b1;
        end
        check("abort reached strobe", seen, 1);
        reset_n[1] = 1'b0;
        #1;
        check("abort strobes/oe/busy/ack",
              {sram_ce_n[1], sram_oe_n[1], sram_we_n[1], sram_oe[1], busy[1], cpu_ack[1], adc_ack[1]},
              7'b1110000);
        check("abort sram_addr", sram_addr[1], 0);
        idle_inputs(1);
        @(negedge clk);
        reset_n[1] = 1'b1;
        acks_after = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (cpu_ack[1] || adc_ack[1] || busy[1]) acks_after++;
        end
        check("no activity after abort", acks_after, 0);

        for (int k = 0; k < N; k++) begin
            idle_inputs(k);
            rand_run(k, 600);
        end

        @(negedge clk);
        for (int k = 0; k < N; k++) check("bus contention cycles", viol[k], 0);

        cyc = n_checks;
        $display("%0d/%0d checks passed", n_pass, cyc);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
        $fatal(1);
    end

endmodule
